// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART constants: data width, oversampling ticks, and the
//          one-hot encodings of the transmit-arbiter state machine.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int BITS_PER_DATA = 8;
    localparam int NUM_TICKS     = 16;

    localparam int c_state_w = 5;
    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_idle  = 5'b00001;
    localparam state_t c_st_load  = 5'b00010;
    localparam state_t c_st_start = 5'b00100;
    localparam state_t c_st_wait  = 5'b01000;
    localparam state_t c_st_done  = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
// Module : rr_arbiter_2
// Brief  : Two-way round-robin selector; the pointer holder wins a tie.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req[0] && (!req[1] || !ptr)) begin
            grant[0] = 1'b1;
        end else if (req[1]) begin
            grant[1] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module : uart_tx_arbiter
// Brief  : Round-robin arbiter sharing one UART transmitter between two
//          requesters. Define UART_TX_ARB_TIMEOUT_EN to enable the WAIT timeout.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int BITS_PER_DATA  = uart_pkg::BITS_PER_DATA,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic                     req1,
    input  logic [BITS_PER_DATA-1:0] data0,
    input  logic [BITS_PER_DATA-1:0] data1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     done0,
    output logic                     done1,
    input  logic                     cfg_parity,
    input  logic [1:0]               cfg_stop_bits,
    output logic                     tx_start,
    output logic [BITS_PER_DATA-1:0] tx_data,
    output logic                     tx_parity,
    output logic [1:0]               tx_stop_bits,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     timeout_err
);

    import uart_pkg::*;

    state_t                   r_state;
    state_t                   w_next_state;
    logic                     r_ptr;
    logic                     r_winner;
    logic [BITS_PER_DATA-1:0] r_tx_data;
    logic                     r_tx_parity;
    logic [1:0]               r_tx_stop;
    logic                     r_tx_done_q;
    logic [1:0]               w_grant;
    logic                     w_tx_done_rise;
    logic                     w_timeout;

    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    rr_arbiter_2 u_rr (
        .req   ({req1, req0}),
        .ptr   (r_ptr),
        .grant (w_grant)
    );

    // Completion is an edge, so a level left high from an earlier frame is ignored.
    assign w_tx_done_rise = tx_done && !r_tx_done_q;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_cnt_w-1:0] r_wait_cnt;
    logic               r_timeout_err;

    assign w_timeout = (r_state == c_st_wait) &&
                       (r_wait_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout && !w_tx_done_rise;
            if (r_state == c_st_wait) begin
                r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (|w_grant) w_next_state = c_st_load;
            c_st_load:  w_next_state = c_st_start;
            c_st_start: w_next_state = c_st_wait;
            c_st_wait: begin
                if (w_tx_done_rise) begin
                    w_next_state = c_st_done;
                end else if (w_timeout) begin
                    w_next_state = c_st_idle;
                end
            end
            c_st_done:  w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        gnt0     = (r_state == c_st_load) && !r_winner;
        gnt1     = (r_state == c_st_load) &&  r_winner;
        done0    = (r_state == c_st_done) && !r_winner;
        done1    = (r_state == c_st_done) &&  r_winner;
        tx_start = (r_state == c_st_start);
        busy     = (r_state != c_st_idle);
    end

    // Frame fields are captured on the IDLE->LOAD edge and held until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= 1'b0;
            r_winner    <= 1'b0;
            r_tx_data   <= '0;
            r_tx_parity <= 1'b0;
            r_tx_stop   <= 2'd1;
            r_tx_done_q <= 1'b0;
        end else begin
            r_tx_done_q <= tx_done;
            if ((r_state == c_st_idle) && (|w_grant)) begin
                r_winner    <= w_grant[1];
                r_ptr       <= !w_grant[1];
                r_tx_data   <= w_grant[1] ? data1 : data0;
                r_tx_parity <= cfg_parity;
                r_tx_stop   <= (cfg_stop_bits == 2'd0) ? 2'd1 : cfg_stop_bits;
            end
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_parity    = r_tx_parity;
    assign tx_stop_bits = r_tx_stop;

endmodule

`default_nettype wire
